accel_frame_packer: RTL and testbench
=====================================

Name: accel_frame_packer

Overview:
- Sits directly downstream of the SPI accelerometer master.
- Captures each completed x/y/z sample on the done_read pulse and serialises it into a fixed byte frame: header, six data bytes, XOR checksum.
- Streams the frame out over a valid/ready byte interface to the UART/Bluetooth transmitter.
- Provides one-deep sample buffering, sample decimation and drop accounting.

Parameters:
- DECIM, 1, forward every DECIM-th accepted done_read pulse; legal range 1..255.
- HDR_BYTE, 8'hA5, frame header value.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- done_read  in  1  one-cycle pulse: x_axis/y_axis/z_axis are valid this cycle
- x_axis  in  16  X sample, sign-extended two's complement
- y_axis  in  16  Y sample
- z_axis  in  16  Z sample
- tx_data  out  8  frame byte to the transmitter
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  transmitter accepts a byte when tx_valid && tx_ready
- busy  out  1  a frame is in progress or the pending buffer is full
- drop_count  out  8  saturating count of overwritten (lost) samples

Behaviour:
- Clock and reset:
  - Single clock clk; rst is synchronous and active-high.
  - Reset values: tx_data=0, tx_valid=0, busy=0, drop_count=0, decimation counter=0, pending buffer empty, state IDLE.
- Decimation:
  - The counter increments on each done_read.
  - A sample is accepted when counter==DECIM-1, and the counter then returns to 0.
  - DECIM=1 accepts every pulse.
- Frame format, in transmission order: HDR_BYTE, X[7:0], X[15:8], Y[7:0], Y[15:8], Z[7:0], Z[15:8], CSUM.
  - Length is 8 bytes.
  - CSUM = XOR of all bytes after the header.
- State machine:
  - IDLE -> SEND on an accepted sample or a pending-valid condition.
  - SEND steps a byte index 0..7.
  - From SEND, after the last byte is accepted: go to IDLE, or stay in SEND at index 0 if pending is valid.
- Capture and latency:
  - An accepted sample in IDLE is latched into the frame register.
  - tx_valid=1 with tx_data=HDR_BYTE the cycle after done_read (1-cycle latency).
- Handshake rules:
  - Once tx_valid is high, tx_data holds stable until tx_valid && tx_ready.
  - The byte index advances only on that handshake.
  - tx_valid never drops mid-frame unless rst is asserted.
  - Consecutive bytes may be accepted on consecutive cycles (full throughput: 8 cycles per frame with tx_ready held high).
- Sample arrival during SEND:
  - An accepted sample goes to the pending buffer.
  - If pending is already full, it is overwritten with the newest sample and drop_count increments (saturates at 255).
- Frame completion:
  - If pending is valid on the last-byte handshake (including a capture in that same cycle), the pending sample moves into the frame register.
  - The header of the next frame is presented on the next cycle: back-to-back, no idle cycle.
- The checksum is accumulated as bytes are loaded, so CSUM is ready when index 7 is reached; no extra cycle.
- busy = (state != IDLE) || pending_valid.
- rst asserted mid-frame:
  - The frame is abandoned and pending is cleared.
  - tx_valid=0 on the following cycle; no partial checksum is emitted.
- done_read coincident with rst is ignored.

Optional Feature:
- Macro: ACCEL_FRAME_SEQ_EN.
- When defined:
  - An 8-bit sequence byte is inserted after the header, making the frame 9 bytes.
  - The sequence byte is included in CSUM.
  - It starts at 0x00 after reset, increments once per completed frame, and wraps 0xFF->0x00.
- When undefined: 8-byte frame, no sequence logic.

Decomposition:
- Package accel_frame_pkg:
  - HDR default constant.
  - FRAME_LEN constant (8, or 9 under the macro).
  - Byte-index typedef.
  - State enum {IDLE, SEND}.
- Sub-module accel_frame_csum: running XOR accumulator with clear/load/enable, instantiated once.

Test Plan:
- Single frame:
  - Stimulus: DECIM=1, tx_ready=1; one done_read with x=0x1234, y=0x5678, z=0x9ABC.
  - Required: bytes A5,34,12,78,56,BC,9A,2E on 8 consecutive cycles; tx_valid rises 1 cycle after done_read; busy falls after the last byte.
- Backpressure:
  - Stimulus: tx_ready toggled 1-of-3 cycles.
  - Required: tx_data is stable while tx_valid&&!tx_ready; the same 8-byte sequence is delivered with no duplication or skips.
- Pending and overwrite:
  - Stimulus: tx_ready=0 during the frame; three done_reads issued with samples A, B, C.
  - Required: frame A completes, frame C follows back-to-back, B is never sent, drop_count=1.
- Decimation:
  - Stimulus: DECIM=3; six done_reads.
  - Required: exactly 2 frames, carrying the 3rd and 6th samples.
- Reset mid-frame:
  - Stimulus: rst after the 4th byte handshake.
  - Required: tx_valid=0 next cycle; the next done_read yields a fresh frame starting with A5 and a correct CSUM.
- ACCEL_FRAME_SEQ_EN:
  - Stimulus: 257 frames.
  - Required: sequence bytes 00..FF then 00; CSUM includes the sequence byte (first frame with the sample above gives 2E).

Source files
------------

// File: rtl/accel_frame_pkg.sv
// accel_frame_pkg: shared constants and types for the accelerometer frame packer.
// Optional build macro ACCEL_FRAME_SEQ_EN adds a sequence byte after the header
// (frame grows from 8 to 9 bytes).
package accel_frame_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

`ifdef ACCEL_FRAME_SEQ_EN
  localparam int SEQ_LEN = 1;
`else
  localparam int SEQ_LEN = 0;
`endif

  localparam int FRAME_LEN = 8 + SEQ_LEN;

  typedef logic [3:0] byte_idx_t;

  // first X byte and the checksum slot
  localparam byte_idx_t DATA_IDX0 = byte_idx_t'(1 + SEQ_LEN);
  localparam byte_idx_t LAST_IDX  = byte_idx_t'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  // x in the low bits so byte n of the flattened vector is frame data byte n
  typedef struct packed {
    logic [15:0] z;
    logic [15:0] y;
    logic [15:0] x;
  } sample_t;

endpackage

// File: rtl/accel_frame_csum.sv
// accel_frame_csum: running XOR checksum register.
// Ports: clk/rst (sync, active-high); clear zeroes the register; load sets it
// to load_val (frame start); en folds din in. Priority: rst/clear > load > en.
module accel_frame_csum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  input  logic [7:0] din,
  output logic [7:0] csum
);

  always_ff @(posedge clk) begin
    if (rst || clear) csum <= '0;
    else if (load)    csum <= load_val;
    else if (en)      csum <= csum ^ din;
  end

endmodule

// File: rtl/accel_frame_packer.sv
// accel_frame_packer: captures x/y/z samples on done_read (with decimation),
// serialises them as HDR, [SEQ], X lo/hi, Y lo/hi, Z lo/hi, CSUM over a
// valid/ready byte stream. One-deep pending buffer, saturating drop counter.
// Ports: clk, rst (sync, active-high); done_read + x/y/z_axis sample input;
// tx_data/tx_valid/tx_ready byte stream; busy; drop_count.
// Macro ACCEL_FRAME_SEQ_EN: insert a per-frame sequence byte after the header.
module accel_frame_packer
  import accel_frame_pkg::*;
#(
  parameter int         DECIM    = 1,
  parameter logic [7:0] HDR_BYTE = HDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done_read,
  input  logic [15:0] x_axis,
  input  logic [15:0] y_axis,
  input  logic [15:0] z_axis,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic        busy,
  output logic [7:0]  drop_count
);

  state_t    state, state_nxt;
  byte_idx_t idx;
  sample_t   frame_q, pend_q, smp_in;
  logic      pend_vld;
  logic [7:0] dec_cnt, csum, csum_init;
  logic [2:0] data_sel;
  logic      accept, hs, last_hs, next_frame, start;

  assign smp_in     = '{z: z_axis, y: y_axis, x: x_axis};
  assign accept     = done_read && (dec_cnt == 8'(DECIM - 1));
  assign hs         = tx_valid && tx_ready;
  assign last_hs    = hs && (idx == LAST_IDX);
  assign next_frame = accept || pend_vld;
  // new frame loads either from IDLE or back-to-back on the final handshake
  assign start      = next_frame && ((state == IDLE) || last_hs);
  assign data_sel   = 3'(idx - DATA_IDX0);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (next_frame) state_nxt = SEND;
      SEND: if (last_hs && !next_frame) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ACCEL_FRAME_SEQ_EN
  logic [7:0] seq_q;

  always_ff @(posedge clk) begin
    if (rst)          seq_q <= '0;
    else if (last_hs) seq_q <= seq_q + 8'd1;
  end

  // a back-to-back frame starts on the edge that bumps seq_q
  assign csum_init = last_hs ? seq_q + 8'd1 : seq_q;
`else
  assign csum_init = 8'h00;
`endif

  // outputs
  always_comb begin
    tx_valid = (state == SEND);
    busy     = (state != IDLE) || pend_vld;
    tx_data  = '0;
    if (state == SEND) begin
      if (idx == '0)            tx_data = HDR_BYTE;
      else if (idx == LAST_IDX) tx_data = csum;
`ifdef ACCEL_FRAME_SEQ_EN
      else if (idx == 4'd1)     tx_data = seq_q;
`endif
      else                      tx_data = frame_q[{data_sel, 3'b000} +: 8];
    end
  end

  // datapath: decimation, byte index, frame/pending capture, drop accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt    <= '0;
      idx        <= '0;
      frame_q    <= '0;
      pend_q     <= '0;
      pend_vld   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (done_read) dec_cnt <= accept ? 8'd0 : dec_cnt + 8'd1;
      if (hs)        idx     <= last_hs ? byte_idx_t'(0) : idx + byte_idx_t'(1);
      if (start) begin
        // a capture on the final handshake is newer than pending, so it wins
        frame_q  <= accept ? smp_in : pend_q;
        pend_vld <= 1'b0;
        if (accept && pend_vld && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end else if (accept) begin
        pend_q   <= smp_in;
        pend_vld <= 1'b1;
        if (pend_vld && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  // checksum accumulates data bytes as they go out; ready when idx hits LAST_IDX
  accel_frame_csum u_csum (
    .clk      (clk),
    .rst      (rst),
    .clear    (last_hs && !next_frame),
    .load     (start),
    .en       (hs && (idx >= DATA_IDX0) && (idx < LAST_IDX)),
    .load_val (csum_init),
    .din      (tx_data),
    .csum     (csum)
  );

endmodule

// File: tb/tb_accel_frame_packer.sv
// Scoreboard bench for accel_frame_packer: stimulus pushes expected frame bytes,
// per-DUT monitors pop and compare on each tx handshake and check data hold.
// Two instances: DECIM=1 (main) and DECIM=3 (decimation).
module tb_accel_frame_packer;

  localparam int LEN = accel_frame_pkg::FRAME_LEN;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        dr1 = 0, dr3 = 0, rdy1 = 0, rdy3 = 0;
  logic [15:0] sx = 0, sy = 0, sz = 0;
  logic [7:0]  d1, d3, dc1, dc3;
  logic        v1, v3, b1, b3;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] q1[$], q3[$];
  logic [7:0] seq1 = 0, seq3 = 0;

  accel_frame_packer #(.DECIM(1)) dut (
    .clk(clk), .rst(rst), .done_read(dr1), .x_axis(sx), .y_axis(sy), .z_axis(sz),
    .tx_data(d1), .tx_ready(rdy1), .tx_valid(v1), .busy(b1), .drop_count(dc1));

  accel_frame_packer #(.DECIM(3)) dut3 (
    .clk(clk), .rst(rst), .done_read(dr3), .x_axis(sx), .y_axis(sy), .z_axis(sz),
    .tx_data(d3), .tx_ready(rdy3), .tx_valid(v3), .busy(b3), .drop_count(dc3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // expected frame: A5, [seq], X lo/hi, Y lo/hi, Z lo/hi, XOR of all after header
  task automatic push_frame(input int w, input logic [15:0] px, py, pz);
    logic [7:0]  b[$];
    logic [7:0]  cs, bt;
    logic [47:0] smp;
    cs  = 8'h00;
    smp = {pz, py, px};
    b.push_back(8'hA5);
`ifdef ACCEL_FRAME_SEQ_EN
    bt = (w == 1) ? seq1 : seq3;
    b.push_back(bt);
    cs ^= bt;
    if (w == 1) seq1++; else seq3++;
`endif
    for (int i = 0; i < 6; i++) begin
      bt = smp[8*i +: 8];
      b.push_back(bt);
      cs ^= bt;
    end
    b.push_back(cs);
    foreach (b[i]) if (w == 1) q1.push_back(b[i]); else q3.push_back(b[i]);
  endtask

  // one-cycle done_read; returns just after the capturing edge
  task automatic pulse(input int w, input logic [15:0] px, py, pz);
    sx = px; sy = py; sz = pz;
    if (w == 1) dr1 = 1; else dr3 = 1;
    tick(1);
    dr1 = 0; dr3 = 0;
  endtask

  // monitors
  logic       hold1 = 0, hold3 = 0;
  logic [7:0] pd1 = 0, pd3 = 0;

  always @(negedge clk) begin
    if (rst) hold1 = 0;
    else begin
      if (hold1) begin
        chk("hold_valid1", v1, 1'b1);
        chk("hold_data1", d1, pd1);
      end
      if (v1 && rdy1) begin
        if (q1.size() == 0) chk("extra_byte1", d1, 9'h100);
        else chk("byte1", d1, q1.pop_front());
      end
      hold1 = v1 && !rdy1;
      pd1   = d1;
    end
  end

  always @(negedge clk) begin
    if (rst) hold3 = 0;
    else begin
      if (hold3) begin
        chk("hold_valid3", v3, 1'b1);
        chk("hold_data3", d3, pd3);
      end
      if (v3 && rdy3) begin
        if (q3.size() == 0) chk("extra_byte3", d3, 9'h100);
        else chk("byte3", d3, q3.pop_front());
      end
      hold3 = v3 && !rdy3;
      pd3   = d3;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    // reset state
    tick(3);
    chk("rst_valid", v1, 0);   chk("rst_data", d1, 0);
    chk("rst_busy", b1, 0);    chk("rst_drop", dc1, 0);
    chk("rst_valid3", v3, 0);  chk("rst_busy3", b3, 0);
    rst = 0;
    tick(2);

    // single frame, full throughput, 1-cycle latency
    rdy1 = 1;
    sx = 16'h1234; sy = 16'h5678; sz = 16'h9ABC; dr1 = 1;
    chk("lat_pre_valid", v1, 0);
    push_frame(1, 16'h1234, 16'h5678, 16'h9ABC);
    tick(1); dr1 = 0;
    chk("lat_valid", v1, 1);
    chk("lat_hdr", d1, 8'hA5);
    tick(LEN);
    chk("single_drained", q1.size(), 0);
    chk("single_busy", b1, 0);
    chk("single_valid", v1, 0);
    tick(2);

    // pending + overwrite: A sent, B dropped, C back-to-back
    rdy1 = 0;
    pulse(1, 16'h1111, 16'h2222, 16'h3333);
    pulse(1, 16'h4444, 16'h5555, 16'h6666);
    pulse(1, 16'h7777, 16'h8888, 16'hFFFF);
    push_frame(1, 16'h1111, 16'h2222, 16'h3333);
    push_frame(1, 16'h7777, 16'h8888, 16'hFFFF);
    chk("pend_drop", dc1, 1);
    chk("pend_busy", b1, 1);
    chk("pend_hdr_held", d1, 8'hA5);
    rdy1 = 1;
    tick(2 * LEN);
    chk("pend_drained", q1.size(), 0);
    chk("pend_idle", b1, 0);
    tick(2);

    // backpressure: ready 1 of 3 cycles
    rdy1 = 0;
    pulse(1, 16'h1234, 16'h5678, 16'h9ABC);
    push_frame(1, 16'h1234, 16'h5678, 16'h9ABC);
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      rdy1 = (i % 3 == 0);
      tick(1);
      if (q1.size() == 0 && !b1) begin ok = 1; break; end
    end
    rdy1 = 1;
    chk("bp_drained", ok, 1);
    tick(2);

    // decimation by 3
    rdy3 = 1;
    for (int k = 1; k <= 6; k++) begin
      pulse(3, 16'h0101 * k, 16'h0A0B + k, 16'hF000 | k);
      if (k % 3 == 0) push_frame(3, 16'h0101 * k, 16'h0A0B + k, 16'hF000 | k);
      tick(2);
    end
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (q3.size() == 0 && !b3) begin ok = 1; break; end
    end
    chk("decim_drained", ok, 1);
    chk("decim_drop", dc3, 0);
    tick(4);

    // reset after 4th byte handshake
    rdy1 = 1;
    pulse(1, 16'hCAFE, 16'hBEEF, 16'h0102);
    push_frame(1, 16'hCAFE, 16'hBEEF, 16'h0102);
    tick(4);
    chk("rst_mid_left", q1.size(), LEN - 4);
    rst = 1; rdy1 = 0;
    q1.delete(); q3.delete();
    seq1 = 0; seq3 = 0;
    tick(1);
    chk("rst_mid_valid", v1, 0);
    chk("rst_mid_busy", b1, 0);
    chk("rst_mid_drop", dc1, 0);
    rst = 0; rdy1 = 1;
    tick(1);
    pulse(1, 16'h1234, 16'h5678, 16'h9ABC);
    push_frame(1, 16'h1234, 16'h5678, 16'h9ABC);
    chk("rst_fresh_hdr", d1, 8'hA5);
    tick(LEN);
    chk("rst_fresh_drained", q1.size(), 0);
    tick(2);

`ifdef ACCEL_FRAME_SEQ_EN
    // sequence wrap over 257 frames
    for (int f = 0; f < 257; f++) begin
      pulse(1, 16'h1234, 16'h5678, 16'h9ABC);
      push_frame(1, 16'h1234, 16'h5678, 16'h9ABC);
      tick(LEN);
    end
    chk("seq_drained", q1.size(), 0);
    chk("seq_idle", b1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
